// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch into ir, then step the
// shared datapath through decode, execute, memory and write-back.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] ir,
  input  logic                  br_taken,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [1:0]            alu_src_a,
  output logic                  alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  illegal,
  output logic [2:0]            state
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [6:0]            opcode;
  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [1:0]            ex_a;
  logic                  ex_b;
  logic [1:0]            ex_op;

  assign opcode   = ir_q[6:0];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign legal    = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc;

  // Debug state and the latched instruction are forced to zero while in reset
  assign state = rst ? 3'd0 : state_q;
  assign ir    = rst ? '0 : ir_q;

  // State register and instruction register; ir only loads on an accepted fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= NOP;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF && imem_ack) begin
        ir_q <= inst;
      end
    end
  end

  // ALU operand/op selection per instruction class, held from EX through WB
  always_comb begin
    ex_a  = 2'b00;
    ex_b  = 1'b0;
    ex_op = 2'b00;
    if (is_r) begin
      ex_op = 2'b10;
    end else if (is_i) begin
      ex_b  = 1'b1;
      ex_op = 2'b10;
    end else if (is_br) begin
      ex_op = 2'b01;
    end else if (is_lui) begin
      ex_a = 2'b10;
      ex_b = 1'b1;
    end else if (is_auipc || is_jal) begin
      ex_a = 2'b01;
      ex_b = 1'b1;
    end else if (is_load || is_store || is_jalr) begin
      ex_b = 1'b1;
    end
  end

  // Next-state logic and all datapath strobes/selects, silenced during reset
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    illegal   = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_ID;
      end
      S_ID: begin
        state_d = legal ? S_EX : S_TRAP;
      end
      S_EX: begin
        alu_src_a = ex_a;
        alu_src_b = ex_b;
        alu_op    = ex_op;
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_src_a = ex_a;
        alu_src_b = ex_b;
        alu_op    = ex_op;
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_src_a = ex_a;
        alu_src_b = ex_b;
        alu_op    = ex_op;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        if (is_load) wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        if (is_jal) pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
        state_d = S_IF;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
    if (rst) begin
      imem_req  = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = 2'b00;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'b00;
      illegal   = 1'b0;
    end
  end

endmodule
